// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the RV32 pipeline main control
//               unit: opcode values, ALUOp and write-back select encodings,
//               the control bundle carried into EX, and the M-op sequencer
//               state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] c_OPC_R     = 7'b0110011;
  localparam logic [6:0] c_OPC_I     = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE = 7'b0100011;
  localparam logic [6:0] c_OPC_BR    = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL   = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR  = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;

  // funct7 value that marks an R-type as an M-extension op
  localparam logic [6:0] c_F7_MEXT   = 7'b0000001;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,  // loads, stores, JALR address
    ALU_BR    = 3'b001,
    ALU_R     = 3'b010,
    ALU_I     = 3'b011,
    ALU_JAL   = 3'b100,
    ALU_LUI   = 3'b101,
    ALU_AUIPC = 3'b110,
    ALU_MD    = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } mem_to_reg_e;

  typedef struct packed {
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal_sel;
    logic        jalr_sel;
    mem_to_reg_e mem_to_reg;
    alu_op_e     alu_op;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t c_BUBBLE = '0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_unit_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Pure combinational opcode/funct7 decoder producing the
//               control bundle, an M-op flag and an illegal-encoding flag.
// Ports       : opcode_i   [6:0] instr[6:0]
//               funct7_i   [6:0] instr[31:25]
//               bundle_o         decoded control bundle
//               is_mop_o         R-type with M funct7 and M_EXT enabled
//               is_illegal_o     unknown opcode, or M funct7 with M_EXT=0
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic [6:0]   opcode_i,
  input  logic [6:0]   funct7_i,
  output ctrl_bundle_t bundle_o,
  output logic         is_mop_o,
  output logic         is_illegal_o
);

  logic w_m_enc;
  assign w_m_enc = (funct7_i == c_F7_MEXT);

  always_comb begin
    bundle_o     = c_BUBBLE;
    is_mop_o     = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode_i)
      c_OPC_R: begin
        bundle_o.reg_write = 1'b1;
        if (w_m_enc && (M_EXT != 0)) begin
          bundle_o.alu_op = ALU_MD;
          is_mop_o        = 1'b1;
        end else begin
          bundle_o.alu_op = ALU_R;
          // An M encoding on a core without M is still executed as plain
          // R-type unless the trap option chooses to act on this flag.
          is_illegal_o    = w_m_enc;
        end
      end
      c_OPC_I: begin
        bundle_o.alu_src   = 1'b1;
        bundle_o.reg_write = 1'b1;
        bundle_o.alu_op    = ALU_I;
      end
      c_OPC_LOAD: begin
        bundle_o.alu_src    = 1'b1;
        bundle_o.reg_write  = 1'b1;
        bundle_o.mem_read   = 1'b1;
        bundle_o.mem_to_reg = WB_MEM;
        bundle_o.alu_op     = ALU_ADD;
      end
      c_OPC_STORE: begin
        bundle_o.alu_src   = 1'b1;
        bundle_o.mem_write = 1'b1;
        bundle_o.alu_op    = ALU_ADD;
      end
      c_OPC_BR: begin
        bundle_o.branch = 1'b1;
        bundle_o.alu_op = ALU_BR;
      end
      c_OPC_JAL: begin
        bundle_o.alu_src    = 1'b1;
        bundle_o.reg_write  = 1'b1;
        bundle_o.jal_sel    = 1'b1;
        bundle_o.mem_to_reg = WB_PC4;
        bundle_o.alu_op     = ALU_JAL;
      end
      c_OPC_JALR: begin
        bundle_o.alu_src    = 1'b1;
        bundle_o.reg_write  = 1'b1;
        bundle_o.jalr_sel   = 1'b1;
        bundle_o.mem_to_reg = WB_PC4;
        bundle_o.alu_op     = ALU_ADD;
      end
      c_OPC_LUI: begin
        bundle_o.alu_src   = 1'b1;
        bundle_o.reg_write = 1'b1;
        bundle_o.alu_op    = ALU_LUI;
      end
      c_OPC_AUIPC: begin
        bundle_o.alu_src   = 1'b1;
        bundle_o.reg_write = 1'b1;
        bundle_o.alu_op    = ALU_AUIPC;
      end
      default: begin
        is_illegal_o = 1'b1;
      end
    endcase
  end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_unit
// Description : Registered, stall/flush-aware main control unit for the
//               5-stage RV32 pipeline. Decodes the ID instruction, registers
//               the control bundle into ID/EX, and sequences multi-cycle
//               M-extension ops (front end stalled via busy).
// Ports       : clk, rst_n (async, active-low)
//               id_valid, opcode[6:0], funct7[6:0]    ID-stage inputs
//               stall_in, flush_in                    hazard/redirect
//               ex_valid + control outputs            registered EX bundle
//               md_start, md_abort                    M-unit pulses
//               busy                                  front-end stall request
//               illegal                               registered trap flag
// Macro       : PIPE_CTRL_ILLEGAL_TRAP_EN - when defined, undefined opcodes
//               (and M encodings with M_EXT=0) issue a bubble with illegal=1.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int M_EXT      = 1,
  parameter int ALUOP_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [6:0]         opcode,
  input  logic [6:0]         funct7,
  input  logic               stall_in,
  input  logic               flush_in,
  output logic               ex_valid,
  output logic               alu_src,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch,
  output logic               jal_sel,
  output logic               jalr_sel,
  output logic [1:0]         mem_to_reg,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               md_start,
  output logic               md_abort,
  output logic               busy,
  output logic               illegal
);

  localparam logic [3:0] c_CNT_LOAD = 4'(MD_LATENCY - 1);

  ctrl_bundle_t w_dec;
  logic         w_is_mop;
  logic         w_dec_illegal;
  logic         w_trap;

  ctrl_decode #(
    .M_EXT(M_EXT)
  ) u_decode (
    .opcode_i    (opcode),
    .funct7_i    (funct7),
    .bundle_o    (w_dec),
    .is_mop_o    (w_is_mop),
    .is_illegal_o(w_dec_illegal)
  );

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
  assign w_trap = w_dec_illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = w_dec_illegal;
  assign w_trap           = 1'b0;
`endif

  md_state_e    state_q;
  logic [3:0]   cnt_q;
  ctrl_bundle_t mop_q;        // M-op bundle parked until the result is due
  ctrl_bundle_t ex_q;
  logic         ex_valid_q;
  logic         md_start_q;
  logic         md_abort_q;
  logic         illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      mop_q      <= c_BUBBLE;
      ex_q       <= c_BUBBLE;
      ex_valid_q <= 1'b0;
      md_start_q <= 1'b0;
      md_abort_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      md_start_q <= 1'b0;
      md_abort_q <= 1'b0;
      illegal_q  <= 1'b0;
      if (flush_in) begin
        // Redirect kills EX and any in-flight M-op; an M-op arriving in the
        // same cycle is simply never started.
        ex_q       <= c_BUBBLE;
        ex_valid_q <= 1'b0;
        md_abort_q <= (state_q != MD_IDLE);
        state_q    <= MD_IDLE;
        cnt_q      <= '0;
        mop_q      <= c_BUBBLE;
      end else begin
        case (state_q)
          MD_IDLE: begin
            if (!stall_in) begin
              if (!id_valid) begin
                ex_q       <= c_BUBBLE;
                ex_valid_q <= 1'b0;
              end else if (w_is_mop) begin
                md_start_q <= 1'b1;
                mop_q      <= w_dec;
                ex_q       <= c_BUBBLE;
                ex_valid_q <= 1'b0;
                cnt_q      <= c_CNT_LOAD;
                state_q    <= MD_BUSY;
              end else if (w_trap) begin
                ex_q       <= c_BUBBLE;
                ex_valid_q <= 1'b0;
                illegal_q  <= 1'b1;
              end else begin
                ex_q       <= w_dec;
                ex_valid_q <= 1'b1;
              end
            end
          end
          MD_BUSY: begin
            // Counts regardless of stall so the M-unit timing stays fixed;
            // EX already holds the bubble written at acceptance.
            if (cnt_q <= 4'd1) begin
              cnt_q   <= '0;
              state_q <= MD_DONE;
            end else begin
              cnt_q   <= cnt_q - 4'd1;
            end
          end
          MD_DONE: begin
            if (!stall_in) begin
              ex_q       <= mop_q;
              ex_valid_q <= 1'b1;
              mop_q      <= c_BUBBLE;
              state_q    <= MD_IDLE;
            end
          end
          default: begin
            state_q <= MD_IDLE;
          end
        endcase
      end
    end
  end

  assign busy       = (state_q != MD_IDLE);
  assign ex_valid   = ex_valid_q;
  assign alu_src    = ex_q.alu_src;
  assign reg_write  = ex_q.reg_write;
  assign mem_read   = ex_q.mem_read;
  assign mem_write  = ex_q.mem_write;
  assign branch     = ex_q.branch;
  assign jal_sel    = ex_q.jal_sel;
  assign jalr_sel   = ex_q.jalr_sel;
  assign mem_to_reg = ex_q.mem_to_reg;
  assign alu_op     = ex_q.alu_op;
  assign md_start   = md_start_q;
  assign md_abort   = md_abort_q;
  assign illegal    = illegal_q;

endmodule : pipe_ctrl_unit
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl_unit
// Description : Directed self-checking bench for pipe_ctrl_unit
//               (MD_LATENCY=4, M_EXT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       stall_in;
  logic       flush_in;
  logic       ex_valid;
  logic       alu_src, reg_write, mem_read, mem_write, branch, jal_sel, jalr_sel;
  logic [1:0] mem_to_reg;
  logic [2:0] alu_op;
  logic       md_start, md_abort, busy, illegal;

  int n_chk = 0;
  int n_err = 0;

  pipe_ctrl_unit #(
    .MD_LATENCY(4),
    .M_EXT     (1),
    .ALUOP_W   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .opcode    (opcode),
    .funct7    (funct7),
    .stall_in  (stall_in),
    .flush_in  (flush_in),
    .ex_valid  (ex_valid),
    .alu_src   (alu_src),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .branch    (branch),
    .jal_sel   (jal_sel),
    .jalr_sel  (jalr_sel),
    .mem_to_reg(mem_to_reg),
    .alu_op    (alu_op),
    .md_start  (md_start),
    .md_abort  (md_abort),
    .busy      (busy),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Bundle order: alu_src reg_write mem_read mem_write branch jal jalr | m2r | aluop
  localparam logic [11:0] B_ZERO  = {7'b0000000, 2'b00, 3'b000};
  localparam logic [11:0] B_R     = {7'b0100000, 2'b00, 3'b010};
  localparam logic [11:0] B_ADDI  = {7'b1100000, 2'b00, 3'b011};
  localparam logic [11:0] B_LW    = {7'b1110000, 2'b01, 3'b000};
  localparam logic [11:0] B_SW    = {7'b1001000, 2'b00, 3'b000};
  localparam logic [11:0] B_BR    = {7'b0000100, 2'b00, 3'b001};
  localparam logic [11:0] B_JAL   = {7'b1100010, 2'b10, 3'b100};
  localparam logic [11:0] B_JALR  = {7'b1100001, 2'b10, 3'b000};
  localparam logic [11:0] B_LUI   = {7'b1100000, 2'b00, 3'b101};
  localparam logic [11:0] B_AUIPC = {7'b1100000, 2'b00, 3'b110};
  localparam logic [11:0] B_MUL   = {7'b0100000, 2'b00, 3'b111};

  function automatic logic [11:0] bund();
    return {alu_src, reg_write, mem_read, mem_write, branch, jal_sel, jalr_sel,
            mem_to_reg, alu_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7);
    id_valid = v;
    opcode   = op;
    funct7   = f7;
  endtask

  initial begin
    rst_n    = 1'b0;
    stall_in = 1'b0;
    flush_in = 1'b0;
    drive(1'b0, 7'b0000000, 7'b0000000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("reset_bundle", {20'b0, bund()}, {20'b0, B_ZERO});
    chk("reset_pulses", {28'b0, md_start, md_abort, busy, illegal}, 32'd0);

    // Plain R-type, then an asynchronous reset mid-stream
    drive(1'b1, 7'b0110011, 7'b0000000);
    tick();
    chk("add_valid", {31'b0, ex_valid}, 32'd1);
    chk("add_bundle", {20'b0, bund()}, {20'b0, B_R});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("async_rst_bundle", {20'b0, bund()}, {20'b0, B_ZERO});
    tick();
    rst_n = 1'b1;

    // LW
    drive(1'b1, 7'b0000011, 7'b0000000);
    tick();
    chk("lw_valid", {31'b0, ex_valid}, 32'd1);
    chk("lw_bundle", {20'b0, bund()}, {20'b0, B_LW});
    drive(1'b0, 7'b0000000, 7'b0000000);
    tick();
    chk("idle_bubble", {31'b0, ex_valid}, 32'd0);

    // MUL, full latency
    drive(1'b1, 7'b0110011, 7'b0000001);
    tick();
    chk("mul_start", {29'b0, md_start, busy, ex_valid}, {29'b0, 3'b110});
    drive(1'b0, 7'b0000000, 7'b0000000);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("mul_busy", {29'b0, md_start, busy, ex_valid}, {29'b0, 3'b010});
    end
    tick();
    chk("mul_issue", {30'b0, busy, ex_valid}, {30'b0, 2'b01});
    chk("mul_bundle", {20'b0, bund()}, {20'b0, B_MUL});
    tick();
    chk("mul_after", {31'b0, ex_valid}, 32'd0);

    // Flush on the 2nd BUSY cycle
    drive(1'b1, 7'b0110011, 7'b0000001);
    tick();
    chk("fl_start", {31'b0, md_start}, 32'd1);
    drive(1'b0, 7'b0000000, 7'b0000000);
    tick();
    flush_in = 1'b1;
    tick();
    chk("fl_abort", {29'b0, md_abort, busy, ex_valid}, {29'b0, 3'b100});
    flush_in = 1'b0;
    drive(1'b1, 7'b0010011, 7'b0000000);
    tick();
    chk("fl_addi", {29'b0, md_abort, busy, ex_valid}, {29'b0, 3'b001});
    chk("fl_addi_bundle", {20'b0, bund()}, {20'b0, B_ADDI});
    drive(1'b0, 7'b0000000, 7'b0000000);
    repeat (5) tick();
    chk("fl_no_late_issue", {30'b0, busy, ex_valid}, 32'd0);

    // Stall while DONE
    drive(1'b1, 7'b0110011, 7'b0000001);
    tick();
    drive(1'b0, 7'b0000000, 7'b0000000);
    repeat (3) tick();
    stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("done_stall", {30'b0, busy, ex_valid}, {30'b0, 2'b10});
    end
    stall_in = 1'b0;
    tick();
    chk("done_release", {30'b0, busy, ex_valid}, {30'b0, 2'b01});
    chk("done_bundle", {20'b0, bund()}, {20'b0, B_MUL});

    // JAL held by stall, then stall+flush kills it
    drive(1'b1, 7'b1101111, 7'b0000000);
    tick();
    chk("jal_bundle", {20'b0, bund()}, {20'b0, B_JAL});
    drive(1'b0, 7'b0000000, 7'b0000000);
    stall_in = 1'b1;
    tick();
    chk("jal_hold", {19'b0, ex_valid, bund()}, {19'b0, 1'b1, B_JAL});
    flush_in = 1'b1;
    tick();
    chk("stall_flush", {19'b0, ex_valid, bund()}, {19'b0, 1'b0, B_ZERO});
    stall_in = 1'b0;
    flush_in = 1'b0;
    drive(1'b1, 7'b0110111, 7'b0000000);
    tick();
    chk("lui", {19'b0, ex_valid, bund()}, {19'b0, 1'b1, B_LUI});

    // Stall in IDLE ignores ID
    stall_in = 1'b1;
    drive(1'b1, 7'b0100011, 7'b0000000);
    tick();
    chk("idle_stall_hold", {19'b0, ex_valid, bund()}, {19'b0, 1'b1, B_LUI});
    stall_in = 1'b0;
    tick();
    chk("sw", {19'b0, ex_valid, bund()}, {19'b0, 1'b1, B_SW});

    // Remaining decodes back to back
    drive(1'b1, 7'b1100011, 7'b0000000);
    tick();
    chk("br", {20'b0, bund()}, {20'b0, B_BR});
    drive(1'b1, 7'b1100111, 7'b0000000);
    tick();
    chk("jalr", {20'b0, bund()}, {20'b0, B_JALR});
    drive(1'b1, 7'b0010111, 7'b0000000);
    tick();
    chk("auipc", {20'b0, bund()}, {20'b0, B_AUIPC});

    // M-op arriving with flush: never started
    drive(1'b1, 7'b0110011, 7'b0000001);
    flush_in = 1'b1;
    tick();
    chk("mop_flush", {28'b0, md_start, md_abort, busy, ex_valid}, 32'd0);
    flush_in = 1'b0;
    drive(1'b0, 7'b0000000, 7'b0000000);
    tick();
    chk("mop_flush_after", {30'b0, busy, md_start}, 32'd0);

    // Reset mid-BUSY: no abort, straight to idle
    drive(1'b1, 7'b0110011, 7'b0000001);
    tick();
    drive(1'b0, 7'b0000000, 7'b0000000);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {28'b0, md_start, md_abort, busy, ex_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rst_busy_after", {29'b0, md_abort, busy, ex_valid}, 32'd0);

    // Undefined opcode
    drive(1'b1, 7'b1111111, 7'b0000000);
    tick();
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    chk("undef", {18'b0, illegal, ex_valid, bund()}, {18'b0, 1'b1, 1'b0, B_ZERO});
`else
    chk("undef", {18'b0, illegal, ex_valid, bund()}, {18'b0, 1'b0, 1'b1, B_ZERO});
`endif
    drive(1'b0, 7'b0000000, 7'b0000000);
    tick();
    chk("undef_after", {30'b0, illegal, ex_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_pipe_ctrl_unit
`default_nettype wire

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Registered, stall/flush-aware main control unit for the 5-stage RV32 pipeline.
- Decodes the ID-stage instruction fields into the control bundle and registers it into the ID/EX boundary.
- Adds LUI/AUIPC decode.
- Adds a multi-cycle sequencer for M-extension ops (MUL/DIV), which stalls the front end for MD_LATENCY cycles.
- Replaces the purely combinational decoder in the ID stage.

Parameters:
- MD_LATENCY, 4, cycles from M-op acceptance to its bundle issuing in EX; legal range 2..15.
- M_EXT, 1, 1 = decode R-type with funct7=0000001 as M-op; 0 = treat it as a plain R-type.
- ALUOP_W, 3, ALUOp width; fixed at 3 (values below).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- id_valid  in  1  ID instruction valid.
- opcode  in  7  instr[6:0].
- funct7  in  7  instr[31:25].
- stall_in  in  1  hazard-unit stall; hold the EX bundle.
- flush_in  in  1  branch/jump redirect; kill the EX bundle.
- ex_valid  out  1  EX bundle valid (0 = bubble).
- alu_src, reg_write, mem_read, mem_write, branch, jal_sel, jalr_sel  out  1 each  registered controls.
- mem_to_reg  out  2  00 ALU, 01 memory, 10 PC+4.
- alu_op  out  3  ALUOp encoding.
- md_start  out  1  one-cycle pulse to the multiplier/divider.
- md_abort  out  1  one-cycle pulse that cancels the in-flight M-op.
- busy  out  1  front-end stall request; combinational from state.
- illegal  out  1  registered; see Optional Feature.

Behaviour:
- Decode (combinational, opcode-indexed):
  - R 0110011: reg_write; alu_op 010.
  - I 0010011: alu_src, reg_write; alu_op 011.
  - LOAD 0000011: alu_src, reg_write, mem_read, mem_to_reg 01; alu_op 000.
  - STORE 0100011: alu_src, mem_write; alu_op 000.
  - BR 1100011: branch; alu_op 001.
  - JAL 1101111: alu_src, reg_write, jal_sel, mem_to_reg 10; alu_op 100.
  - JALR 1100111: alu_src, reg_write, jalr_sel, mem_to_reg 10; alu_op 000.
  - LUI 0110111: alu_src, reg_write; alu_op 101.
  - AUIPC 0010111: alu_src, reg_write; alu_op 110.
  - M-op (R with funct7=0000001, M_EXT=1): reg_write; alu_op 111.
  - Any other opcode: all-zero bundle.
- Reset: every output 0, state IDLE, counter 0.
- Bubble: all controls 0 and ex_valid 0.
- EX register update priority per cycle: flush_in > stall_in > state action.
- State machine:
  - IDLE:
    - id_valid and not an M-op: register the bundle, ex_valid=1, latency 1 cycle.
    - id_valid and M-op: pulse md_start, latch the bundle internally, register a bubble, load counter=MD_LATENCY-1, go BUSY.
  - BUSY:
    - busy=1; EX holds a bubble.
    - Counter decrements every cycle, ignoring stall_in.
    - Counter reaches 0: go DONE.
  - DONE:
    - If stall_in=0: register the latched M-op bundle, ex_valid=1, go IDLE; busy drops in the same cycle.
    - If stall_in=1: remain in DONE with busy=1.
- flush_in:
  - EX register becomes a bubble next cycle.
  - In BUSY or DONE: md_abort pulses, state goes IDLE, latched bundle discarded.
  - md_start and flush_in in the same cycle: flush wins; no BUSY entry, no md_start, no md_abort.
- stall_in in IDLE: EX register unchanged and the ID input is ignored.
- rst_n asserted mid-BUSY: immediate return to IDLE with all outputs 0; no md_abort.
- Total M-op latency: md_start cycle + MD_LATENCY; no stall ⇒ ex_valid for the M-op exactly MD_LATENCY cycles after the md_start edge.

Optional Feature:
- Macro: PIPE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode with id_valid produces a bubble with illegal=1 for one cycle.
  - When M_EXT=0, an M-encoded funct7 also flags illegal.
- Undefined: illegal is tied 0; undefined opcodes issue the all-zero bundle with ex_valid=1.

Decomposition:
- Package pipe_ctrl_pkg:
  - opcode localparams.
  - alu_op_e enum (000..111).
  - mem_to_reg_e enum.
  - ctrl_bundle_t packed struct (all control bits).
  - md_state_e {IDLE, BUSY, DONE}.
- Sub-module ctrl_decode: pure combinational opcode/funct7 → ctrl_bundle_t, instantiated once.

Test Plan:
- rst_n=0 mid-stream, then release; issue LW (0000011) → next cycle ex_valid=1, alu_src=1, mem_read=1, mem_to_reg=01, alu_op=000.
- MD_LATENCY=4: MUL (0110011, funct7=0000001) accepted → md_start pulse; busy=1 for 4 cycles; ex_valid=1 with alu_op=111 and reg_write=1 exactly 4 cycles after the md_start edge.
- flush_in on the 2nd BUSY cycle → md_abort pulses once, next cycle IDLE, busy=0, ex_valid=0; following ADDI issues normally with alu_op=011.
- stall_in=1 while in DONE for 3 cycles → busy stays 1 and no issue; stall released → M-op issues the next cycle.
- stall_in and flush_in together while EX holds a JAL → EX becomes a bubble (flush wins); LUI issued afterwards gives alu_op=101 and alu_src=1.
- With PIPE_CTRL_ILLEGAL_TRAP_EN: opcode 1111111 → illegal=1, ex_valid=0; without the macro → illegal=0, ex_valid=1 with an all-zero bundle.
